// File: rtl/nvram_uploader.sv
`default_nettype none
// =============================================================================
// Module  : nvram_uploader
// Brief   : Streams the CMOS RAM back to the HPS over ioctl upload; tracks dirty.
// Revision: 1.0
// =============================================================================
module nvram_uploader #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 4,
    parameter logic [15:0] NV_INDEX = 16'd4,
    parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [15:0]       ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] nv_addr,
    output logic              nv_rd,
    input  logic [DATA_W-1:0] nv_q,
    input  logic              nv_cpu_wr,
    output logic              dirty,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LATCH = 2'd2,
        S_PAD   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_pending, w_pending_nxt;
    logic [24:0]       r_pend_addr, w_pend_addr_nxt;
    logic [7:0]        r_din, w_din_nxt;
    logic              r_wait, w_wait_nxt;
    logic [ADDR_W-1:0] r_nv_addr, w_nv_addr_nxt;
    logic              r_nv_rd, w_nv_rd_nxt;
    logic [ADDR_W:0]   r_byte_cnt;
    logic              r_wr_during;
    logic              r_dirty;
    logic              r_busy;

    logic              w_sel, w_sess_start, w_sess_end, w_rd;
    logic              w_have_req, w_req_pad, w_launch, w_cnt_inc;
    logic [24:0]       w_req_addr;

    assign w_sel        = ioctl_upload && (ioctl_index == NV_INDEX);
    assign w_sess_start = w_sel && !r_busy;
    assign w_sess_end   = !w_sel && r_busy;
    assign w_rd         = ioctl_rd && w_sel;

    // A request presented this cycle takes priority over (replaces) the pending one.
    assign w_have_req = w_rd || r_pending;
    assign w_req_addr = w_rd ? ioctl_addr : r_pend_addr;
    assign w_req_pad  = (w_req_addr >> ADDR_W) != 25'd0;

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_pend_addr_nxt = r_pend_addr;
        w_din_nxt       = r_din;
        w_wait_nxt      = r_wait;
        w_nv_addr_nxt   = r_nv_addr;
        w_nv_rd_nxt     = 1'b0;
        w_launch        = 1'b0;
        w_cnt_inc       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_launch = w_have_req;
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
                if (w_rd) begin
                    w_pending_nxt   = 1'b1;
                    w_pend_addr_nxt = ioctl_addr;
                end
            end
            S_LATCH: begin
                w_din_nxt   = 8'(nv_q);
                w_cnt_inc   = 1'b1;
                w_wait_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                w_launch    = w_have_req;
            end
            default: begin
                w_din_nxt   = PAD_BYTE;
                w_wait_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                w_launch    = w_have_req;
            end
        endcase

        // Chaining straight out of LATCH/PAD keeps ioctl_wait high between fetches.
        if (w_launch) begin
            w_pending_nxt = 1'b0;
            w_wait_nxt    = 1'b1;
            if (w_req_pad) begin
                w_state_nxt = S_PAD;
            end else begin
                w_state_nxt   = S_FETCH;
                w_nv_addr_nxt = w_req_addr[ADDR_W-1:0];
                w_nv_rd_nxt   = 1'b1;
            end
        end

        if (w_sess_end) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = 1'b0;
            w_wait_nxt    = 1'b0;
            w_nv_rd_nxt   = 1'b0;
            w_din_nxt     = r_din;
            w_cnt_inc     = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_pend_addr <= '0;
            r_din       <= '0;
            r_wait      <= 1'b0;
            r_nv_addr   <= '0;
            r_nv_rd     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_din       <= w_din_nxt;
            r_wait      <= w_wait_nxt;
            r_nv_addr   <= w_nv_addr_nxt;
            r_nv_rd     <= w_nv_rd_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_byte_cnt  <= '0;
            r_wr_during <= 1'b0;
            r_dirty     <= 1'b0;
        end else begin
            r_busy <= w_sel;

            if (w_sess_start) begin
                r_byte_cnt <= '0;
            end else if (w_cnt_inc && (r_byte_cnt != c_DEPTH)) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_sess_start) begin
                r_wr_during <= 1'b0;
            end else if (nv_cpu_wr && r_busy) begin
                r_wr_during <= 1'b1;
            end

            // Only a complete, undisturbed upload proves the saved image is current.
            if (nv_cpu_wr) begin
                r_dirty <= 1'b1;
            end else if (w_sess_end && (r_byte_cnt == c_DEPTH) && !r_wr_during) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign nv_addr    = r_nv_addr;
    assign nv_rd      = r_nv_rd;
    assign dirty      = r_dirty;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nvram_uploader.sv
`default_nettype none
// =============================================================================
// Module  : tb_nvram_uploader
// Brief   : Directed self-checking bench for nvram_uploader.
// Revision: 1.0
// =============================================================================
module tb_nvram_uploader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  nv_addr;
    logic        nv_rd;
    logic [3:0]  nv_q = 4'h0;
    logic        nv_cpu_wr;
    logic        dirty;
    logic        busy;

    logic [3:0]  mem [1024];
    int          checks = 0;
    int          errors = 0;
    int          rd_pulses = 0;

    nvram_uploader dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .nv_addr      (nv_addr),
        .nv_rd        (nv_rd),
        .nv_q         (nv_q),
        .nv_cpu_wr    (nv_cpu_wr),
        .dirty        (dirty),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // CMOS RAM read port: data valid the cycle after the read enable.
    always @(posedge clk_sys) begin
        if (nv_rd) begin
            nv_q <= mem[nv_addr];
            rd_pulses <= rd_pulses + 1;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_session(input logic [15:0] idx);
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        tick();
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        tick();
    endtask

    task automatic cpu_write();
        nv_cpu_wr = 1'b1;
        tick();
        nv_cpu_wr = 1'b0;
    endtask

    // In-range read with cycle-exact latency checks.
    task automatic read_exact(input logic [24:0] addr, input logic [7:0] exp);
        logic [7:0] prev;
        prev       = ioctl_din;
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        tick();
        ioctl_rd = 1'b0;
        check("rd_wait_c1", ioctl_wait, 1);
        check("rd_nvrd_c1", nv_rd, 1);
        tick();
        check("rd_wait_c2", ioctl_wait, 1);
        check("rd_hold_c2", ioctl_din, prev);
        tick();
        check("rd_wait_c3", ioctl_wait, 0);
        check("rd_data_c3", ioctl_din, exp);
    endtask

    task automatic read_pad(input logic [24:0] addr);
        int p0;
        p0         = rd_pulses;
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        tick();
        ioctl_rd = 1'b0;
        check("pad_wait_c1", ioctl_wait, 1);
        tick();
        check("pad_wait_c2", ioctl_wait, 0);
        check("pad_data_c2", ioctl_din, 8'hFF);
        check("pad_no_nvrd", rd_pulses, p0);
    endtask

    // Bulk read of addresses 0..nbytes-1, optional CPU write alongside byte wr_at.
    task automatic bulk_upload(input int nbytes, input int wr_at);
        int bad;
        int n;
        bad = 0;
        for (int a = 0; a < nbytes; a++) begin
            ioctl_rd   = 1'b1;
            ioctl_addr = 25'(a);
            nv_cpu_wr  = (a == wr_at);
            tick();
            ioctl_rd  = 1'b0;
            nv_cpu_wr = 1'b0;
            n = 0;
            while (ioctl_wait && n < 10) begin
                tick();
                n++;
            end
            if (ioctl_wait || ioctl_din !== {4'h0, mem[a]}) bad++;
        end
        check("bulk_data", bad, 0);
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i * 7 + 3);
        mem[0] = 4'h1;
        mem[1] = 4'h2;
        mem[2] = 4'hA;
        mem[3] = 4'hF;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 16'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        nv_cpu_wr    = 1'b0;
        repeat (3) tick();
        check("rst_din", ioctl_din, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_nvaddr", nv_addr, 0);
        check("rst_nvrd", nv_rd, 0);
        check("rst_dirty", dirty, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        cpu_write();
        check("dirty_set", dirty, 1);

        // Basic reads and pad reads.
        start_session(16'd4);
        check("busy_on", busy, 1);
        read_exact(25'd0, 8'h01);
        read_exact(25'd1, 8'h02);
        read_exact(25'd2, 8'h0A);
        read_exact(25'd3, 8'h0F);
        read_pad(25'd1024);
        read_pad(25'h100000);
        end_session();
        check("busy_off", busy, 0);
        check("dirty_partial4", dirty, 1);

        // Full clean upload clears dirty.
        start_session(16'd4);
        bulk_upload(1024, -1);
        end_session();
        check("dirty_full_clear", dirty, 0);

        cpu_write();
        check("dirty_set2", dirty, 1);
        start_session(16'd4);
        bulk_upload(1000, -1);
        end_session();
        check("dirty_1000_keep", dirty, 1);

        // Write mid-upload keeps dirty; next clean upload clears it.
        start_session(16'd4);
        bulk_upload(1024, 500);
        end_session();
        check("dirty_wr_during", dirty, 1);
        start_session(16'd4);
        bulk_upload(1024, -1);
        end_session();
        check("dirty_clean_again", dirty, 0);

        // Back-to-back requests through the pending slot.
        start_session(16'd4);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd2;
        tick();
        check("b2b_wait_c1", ioctl_wait, 1);
        check("b2b_addr_c1", nv_addr, 2);
        ioctl_addr = 25'd3;
        tick();
        ioctl_rd = 1'b0;
        check("b2b_wait_c2", ioctl_wait, 1);
        tick();
        check("b2b_wait_c3", ioctl_wait, 1);
        check("b2b_data1", ioctl_din, 8'h0A);
        check("b2b_nvrd_c3", nv_rd, 1);
        check("b2b_addr_c3", nv_addr, 3);
        tick();
        check("b2b_wait_c4", ioctl_wait, 1);
        tick();
        check("b2b_wait_c5", ioctl_wait, 0);
        check("b2b_data2", ioctl_din, 8'h0F);
        end_session();

        // Wrong index: ignored.
        p0 = rd_pulses;
        start_session(16'd0);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd1;
        tick();
        ioctl_rd = 1'b0;
        check("idx0_wait", ioctl_wait, 0);
        tick();
        tick();
        check("idx0_busy", busy, 0);
        check("idx0_no_nvrd", rd_pulses, p0);
        check("idx0_din_hold", ioctl_din, 8'h0F);
        end_session();

        // Asynchronous reset while in LATCH.
        cpu_write();
        check("dirty_pre_rst", dirty, 1);
        start_session(16'd4);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd0;
        tick();
        ioctl_rd = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("arst_din", ioctl_din, 0);
        check("arst_wait", ioctl_wait, 0);
        check("arst_dirty", dirty, 0);
        check("arst_nvrd", nv_rd, 0);
        check("arst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 1);
        read_exact(25'd0, 8'h01);
        read_exact(25'd1, 8'h02);
        read_exact(25'd2, 8'h0A);
        read_exact(25'd3, 8'h0F);
        end_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- Reader side of the HPS ioctl transfer channel: the download path writes ROM into the core, and this block streams the Williams CMOS RAM (high scores, settings) back to the HPS during an ioctl upload so it can be saved as NVRAM.
- Sits between hps_io (ioctl_upload/ioctl_rd/ioctl_addr/ioctl_din/ioctl_wait) and the read-only second port of the core's 1K x 4 CMOS RAM.
- Tracks a dirty flag from CPU CMOS writes so the top level can request autosave.

Parameters:
ADDR_W, 10, CMOS RAM address width; depth = 2^ADDR_W bytes uploaded
DATA_W, 4, CMOS RAM data width; zero-extended to 8 bits in ioctl_din
NV_INDEX, 16'd4, ioctl_index value that selects this block
PAD_BYTE, 8'hFF, ioctl_din value returned for addresses >= depth

Ports:
clk_sys  in  1  system clock (12 MHz core clock)
reset_n  in  1  asynchronous, active-low reset
ioctl_upload  in  1  level, high for the duration of an HPS upload
ioctl_index  in  16  transfer index; block is active only when equal to NV_INDEX
ioctl_rd  in  1  one-cycle read request for ioctl_addr
ioctl_addr  in  25  byte address of the request
ioctl_din  out  8  read data to HPS
ioctl_wait  out  1  high while a fetch is outstanding
nv_addr  out  ADDR_W  CMOS RAM read address
nv_rd  out  1  CMOS RAM read enable
nv_q  in  DATA_W  CMOS RAM read data, valid exactly 1 cycle after nv_rd
nv_cpu_wr  in  1  CPU write strobe to CMOS RAM (one cycle per write)
dirty  out  1  CMOS contents changed since last complete upload
busy  out  1  upload session in progress (sel and ioctl_upload)

Behaviour:
Reset values: ioctl_din=0, ioctl_wait=0, nv_addr=0, nv_rd=0, dirty=0, busy=0, FSM=IDLE, pending=0, byte_cnt=0, wr_during=0.
- sel = ioctl_upload && (ioctl_index == NV_INDEX). Requests with sel=0 are ignored.
- busy is sel registered by one cycle.

FSM states and transitions:
- IDLE: on ioctl_rd && sel, latch addr.
  - If addr < 2^ADDR_W: drive nv_addr = addr[ADDR_W-1:0], nv_rd=1, go FETCH.
  - Otherwise go PAD.
  - ioctl_wait=1 from the cycle after rd.
- FETCH: nv_rd=0; go LATCH.
- LATCH: ioctl_din <= {zeros, nv_q}; byte_cnt++ (saturating at 2^ADDR_W); ioctl_wait=0; go IDLE.
- PAD: ioctl_din <= PAD_BYTE; ioctl_wait=0; go IDLE. PAD has no RAM access and does not count toward byte_cnt.
- Latency: ioctl_din is valid and ioctl_wait low 3 cycles after the rd pulse for in-range addresses, 2 cycles for pad addresses.
- ioctl_din holds its value until the next completed fetch.
- ioctl_rd arriving while the FSM is not IDLE: latched into a single-deep pending slot (address captured). It is served immediately on return to IDLE with no idle cycle; ioctl_wait stays high across both fetches. A further rd while pending=1 overwrites the pending address.

Session and dirty handling:
- Session start (rising sel): byte_cnt=0, wr_during=0.
- nv_cpu_wr: dirty <= 1 at any time; if busy, wr_during <= 1.
- Session end (falling sel, including upload deasserted mid-fetch): the FSM aborts to IDLE, ioctl_wait=0, and pending is cleared.
  - If byte_cnt == 2^ADDR_W and wr_during == 0 and there is no nv_cpu_wr in the same cycle: dirty <= 0.
  - Otherwise dirty is unchanged.
- Simultaneous nv_cpu_wr and the clear condition: dirty stays 1.
- Address wrap: ioctl_addr bits above ADDR_W are not masked; any nonzero upper bit selects PAD.
- reset_n low at any time, including mid-fetch: all registers return to reset values immediately; nv_rd drops asynchronously.

Test Plan:
1. Preload CMOS[0..3]=4'h1,4'h2,4'hA,4'hF; upload index 4, rd addr 0..3 -> ioctl_din 8'h01,8'h02,8'h0A,8'h0F, each valid 3 cycles after its rd; ioctl_wait high for exactly 2 cycles per read.
2. rd addr 1024 and addr 25'h100000 -> ioctl_din 8'hFF after 2 cycles; nv_rd never asserted; byte_cnt unchanged.
3. nv_cpu_wr pulse -> dirty=1; full 1024-byte upload, then ioctl_upload falls -> dirty=0 one cycle later. Same with only 1000 bytes read -> dirty stays 1.
4. nv_cpu_wr during byte 500 of a full upload -> dirty stays 1 after session end; the next clean full upload clears it.
5. Second rd issued in the FETCH cycle of the first -> both served back-to-back; ioctl_wait high continuously; ioctl_din carries the second byte last. Upload with ioctl_index=0 -> no nv_rd, ioctl_wait stays 0.
6. Assert reset_n=0 in the LATCH state -> ioctl_din=0, ioctl_wait=0, dirty=0 immediately; after release, a new upload works as in scenario 1.
